// File: rtl/mux_rr_select.sv
// Round-robin select generator driving Mux.select: holds one channel per packet
// (or MAX_BURST beats), presents a valid/ready output and a one-hot ack per beat.
module mux_rr_select #(
  parameter int SIZE      = 3,
  parameter int MAX_BURST = 4,
  localparam int CHANNELS = 2 ** SIZE,
  localparam int CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] req,
  input  logic                last,
  input  logic                ready,
  output logic [SIZE-1:0]     select,
  output logic                valid,
  output logic [CHANNELS-1:0] grant,
  output logic [CHANNELS-1:0] ack,
  output logic                dbg_state,
  output logic [SIZE-1:0]     dbg_ptr,
  output logic [CNT_W-1:0]    dbg_beat_cnt
);

  // Handshake: a beat moves when valid & ready on a posedge; valid, select and
  // grant never change while valid=1 and ready=0.
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state;
  logic [SIZE-1:0]     ptr;
  logic [CNT_W-1:0]    beat_cnt;

  logic [SIZE-1:0]     sel_inc;
  logic [CHANNELS-1:0] sel_oh;
  logic [CHANNELS-1:0] rest;
  logic [SIZE-1:0]     first_sel;
  logic [SIZE-1:0]     next_sel;
  logic                xfer;
  logic                grant_end;

  // First set bit of mask, scanning upward from start with wrap-around.
  function automatic logic [SIZE-1:0] arb(input logic [CHANNELS-1:0] mask,
                                          input logic [SIZE-1:0]     start);
    logic [SIZE-1:0] idx;
    arb = start;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = start + SIZE'(i);
      if (mask[idx]) arb = idx;
    end
  endfunction

  assign sel_inc   = select + SIZE'(1);
  assign sel_oh    = CHANNELS'(1) << select;
  assign rest      = req & ~sel_oh;
  assign first_sel = arb(req, ptr);
  assign next_sel  = arb(rest, sel_inc);
  assign xfer      = valid & ready;
  assign grant_end = last | (beat_cnt == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      select   <= '0;
      valid    <= 1'b0;
      grant    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            select   <= first_sel;
            grant    <= CHANNELS'(1) << first_sel;
            valid    <= 1'b1;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            if (grant_end) begin
              ptr <= sel_inc;
              // Finishing channel sits out this arbitration, so a truncated burst rotates.
              if (|rest) begin
                select   <= next_sel;
                grant    <= CHANNELS'(1) << next_sel;
                beat_cnt <= '0;
              end else begin
                valid <= 1'b0;
                grant <= '0;
                state <= IDLE;
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ack          = grant & {CHANNELS{xfer}};
  assign dbg_state    = (state == GRANT);
  assign dbg_ptr      = ptr;
  assign dbg_beat_cnt = beat_cnt;

  a_req_held: assert property (@(posedge clk) disable iff (!reset) valid |-> req[select])
    else $error("granted channel %0d dropped req while valid", select);

endmodule

// File: tb/tb_mux_rr_select.sv
// Bench for mux_rr_select: table-driven vectors, hand-written corner sequences,
// and randomized traffic against a queue-free behavioural arbiter model.
module tb_mux_rr_select;

  localparam int SIZE      = 3;
  localparam int MAX_BURST = 4;
  localparam int CH        = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] req;
  logic          last;
  logic          ready;
  logic [SIZE-1:0] select;
  logic          valid;
  logic [CH-1:0] grant;
  logic [CH-1:0] ack;
  logic          dbg_state;
  logic [SIZE-1:0] dbg_ptr;
  logic [1:0]    dbg_beat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mux_rr_select #(.SIZE(SIZE), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .ready(ready),
    .select(select), .valid(valid), .grant(grant), .ack(ack),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr), .dbg_beat_cnt(dbg_beat_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [CH-1:0] r, input logic l, input logic rd);
    req   = r;
    last  = l;
    ready = rd;
  endtask

  // Reference model: one current owner, beats taken, and a search start point.
  bit m_valid;
  int m_sel;
  int m_ptr;
  int m_beats;

  function automatic int ref_arb(input logic [CH-1:0] mask, input int start);
    for (int k = 0; k < CH; k++)
      if (mask[(start + k) % CH]) return (start + k) % CH;
    return 0;
  endfunction

  task automatic model_step();
    logic [CH-1:0] others;
    if (!m_valid) begin
      if (req != 0) begin
        m_sel   = ref_arb(req, m_ptr);
        m_valid = 1;
        m_beats = 0;
      end
    end else if (ready) begin
      m_beats++;
      if (last || m_beats == MAX_BURST) begin
        m_ptr  = (m_sel + 1) % CH;
        others = req;
        others[m_sel] = 1'b0;
        if (others != 0) begin
          m_sel   = ref_arb(others, m_ptr);
          m_beats = 0;
        end else begin
          m_valid = 0;
        end
      end
    end
  endtask

  // Reset pulse; returns 1 time unit after a posedge with reset released.
  task automatic do_reset();
    reset = 1'b0;
    drive('0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    m_valid = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
  endtask

  typedef struct {
    bit            rst;
    logic [CH-1:0] req;
    logic          last;
    logic          ready;
    logic          exp_valid;
    logic [2:0]    exp_sel;
    logic [CH-1:0] exp_ack;
    bit            chk_ptr;
    logic [2:0]    exp_ptr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, logic [CH-1:0] r, logic l, logic rd,
                              logic ev, int es, logic [CH-1:0] ea);
    vec_t v;
    v.rst = rst; v.req = r; v.last = l; v.ready = rd;
    v.exp_valid = ev; v.exp_sel = 3'(es); v.exp_ack = ea;
    v.chk_ptr = 0; v.exp_ptr = '0;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [CH-1:0] oh;
    reset = 1'b0;
    drive('0, 1'b0, 1'b0);

    // single requester on ch2: one beat, then idle with ptr past it
    vecs.push_back(mk(1, 8'h04, 1, 1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h04, 1, 1, 1, 2, 8'h04));
    v = mk(0, 8'h00, 0, 1, 0, 0, 8'h00); v.chk_ptr = 1; v.exp_ptr = 3'd3;
    vecs.push_back(v);
    // all requesting, single-beat packets: rotation 0..7,0,1 without bubbles
    vecs.push_back(mk(1, 8'hFF, 1, 1, 0, 0, 8'h00));
    for (int i = 0; i < 10; i++) begin
      oh = '0; oh[i % CH] = 1'b1;
      vecs.push_back(mk(0, 8'hFF, 1, 1, 1, i % CH, oh));
    end
    // two requesters, endless packets: MAX_BURST truncation alternates owners
    vecs.push_back(mk(1, 8'h03, 0, 1, 0, 0, 8'h00));
    for (int i = 0; i < 3 * MAX_BURST; i++) begin
      oh = '0; oh[(i / MAX_BURST) % 2] = 1'b1;
      vecs.push_back(mk(0, 8'h03, 0, 1, 1, (i / MAX_BURST) % 2, oh));
    end

    // hold in reset with everything requesting
    drive(8'hFF, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_select", 32'(select), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_ack", 32'(ack), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    drive(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_valid", 32'(valid), 0);
      @(posedge clk);
      #1;
    end

    // table vectors: inputs applied after a posedge, outputs checked at the negedge
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].req, vecs[i].last, vecs[i].ready);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
      if (vecs[i].exp_valid) begin
        oh = '0; oh[vecs[i].exp_sel] = 1'b1;
        check($sformatf("vec%0d_select", i), 32'(select), 32'(vecs[i].exp_sel));
        check($sformatf("vec%0d_grant", i), 32'(grant), 32'(oh));
      end else begin
        check($sformatf("vec%0d_grant", i), 32'(grant), 0);
      end
      if (vecs[i].chk_ptr) check($sformatf("vec%0d_ptr", i), 32'(dbg_ptr), 32'(vecs[i].exp_ptr));
      @(posedge clk);
      #1;
    end

    // backpressure on ch5 after one beat: everything holds, then the beat moves
    do_reset();
    drive(8'h20, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_first_ack", 32'(ack), 32'h20);
    @(posedge clk); #1;
    drive(8'h20, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(valid), 1);
      check("bp_select", 32'(select), 5);
      check("bp_ack", 32'(ack), 0);
      check("bp_beat_cnt", 32'(dbg_beat_cnt), 1);
      @(posedge clk); #1;
    end
    drive(8'h20, 1'b0, 1'b1);
    @(negedge clk);
    check("bp_release_ack", 32'(ack), 32'h20);
    @(posedge clk); #1;
    check("bp_beat_cnt_after", 32'(dbg_beat_cnt), 2);

    // asynchronous reset in the middle of a grant on ch6
    do_reset();
    drive(8'h40, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_select_before", 32'(select), 6);
    #2 reset = 1'b0;
    ready = 1'b1;
    #1;
    check("mid_rst_select", 32'(select), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_ack", 32'(ack), 0);
    req = 8'hFF;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(valid), 1);
    check("post_rst_select", 32'(select), 0);

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [CH-1:0] r;
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = CH'($urandom) & CH'($urandom) & CH'($urandom);
        default: r = CH'($urandom);
      endcase
      if (m_valid) r[m_sel] = 1'b1;
      drive(r, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);
      @(negedge clk);
      oh = '0;
      if (m_valid) oh[m_sel] = 1'b1;
      check("rnd_valid", 32'(valid), 32'(m_valid));
      check("rnd_grant", 32'(grant), 32'(oh));
      check("rnd_ack", 32'(ack), 32'(ready ? oh : '0));
      if (m_valid) check("rnd_select", 32'(select), 32'(m_sel));
      @(posedge clk);
      model_step();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
